// File: rtl/btb_pkg.sv
// Shared types for the 2-way set-associative branch target buffer:
// 2-bit direction counter encoding, entry record and counter update helper.
package btb_pkg;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_e;

    // Widest PC the entry record can carry; real widths are sliced out of it.
    localparam int BTB_MAX_W = 64;

    typedef struct packed {
        logic                 valid;
        logic [BTB_MAX_W-1:0] tag;
        ctr_e                 ctr;
        logic [BTB_MAX_W-1:0] target;
    } btb_entry_t;

    function automatic ctr_e ctr_next(ctr_e cur, logic taken);
        ctr_e nxt;
        nxt = cur;
        if (taken && cur != ST) begin
            nxt = ctr_e'(cur + 2'd1);
        end else if (!taken && cur != SNT) begin
            nxt = ctr_e'(cur - 2'd1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/btb_assoc_if.sv
// Fetch-side lookup/prediction and EX-side update bundle of the BTB.
// Handshake: a lookup is accepted whenever lk_valid is high (no back-pressure);
// its result appears with pr_valid exactly one cycle later. An update is applied
// in the cycle up_valid is high; there is no ready signal on either channel.
interface btb_assoc_if #(
    parameter int PC_W = 16
);
    logic            lk_valid;
    logic [PC_W-1:0] lk_pc;
    logic            pr_valid;
    logic            pr_hit;
    logic            pr_taken;
    logic [PC_W-1:0] pr_target;
    logic            up_valid;
    logic            up_is_br;
    logic [PC_W-1:0] up_pc;
    logic            up_taken;
    logic [PC_W-1:0] up_target;
    logic            up_pred_taken;

    modport master (
        output lk_valid, lk_pc, up_valid, up_is_br, up_pc, up_taken, up_target, up_pred_taken,
        input  pr_valid, pr_hit, pr_taken, pr_target
    );

    modport slave (
        input  lk_valid, lk_pc, up_valid, up_is_br, up_pc, up_taken, up_target, up_pred_taken,
        output pr_valid, pr_hit, pr_taken, pr_target
    );
endinterface

// File: rtl/btb_stats.sv
// Saturating branch / hit / mispredict counters with a priority clear.
module btb_stats #(
    parameter int STAT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              br_inc,
    input  logic              hit_inc,
    input  logic              mispr_inc,
    output logic [STAT_W-1:0] br_cnt,
    output logic [STAT_W-1:0] hit_cnt,
    output logic [STAT_W-1:0] mispr_cnt
);
    logic [STAT_W-1:0] br_q, br_d, hit_q, hit_d, mispr_q, mispr_d;

    always_comb begin
        br_d    = br_q;
        hit_d   = hit_q;
        mispr_d = mispr_q;
        if (clr) begin
            br_d    = '0;
            hit_d   = '0;
            mispr_d = '0;
        end else begin
            if (br_inc && br_q != '1)       br_d    = br_q + 1'b1;
            if (hit_inc && hit_q != '1)     hit_d   = hit_q + 1'b1;
            if (mispr_inc && mispr_q != '1) mispr_d = mispr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_q    <= '0;
            hit_q   <= '0;
            mispr_q <= '0;
        end else begin
            br_q    <= br_d;
            hit_q   <= hit_d;
            mispr_q <= mispr_d;
        end
    end

    assign br_cnt    = br_q;
    assign hit_cnt   = hit_q;
    assign mispr_cnt = mispr_q;
endmodule

// File: rtl/btb_assoc.sv
// 2-way set-associative branch target buffer with 2-bit direction counters,
// per-set LRU, one-cycle lookup and single-cycle EX-stage update.
module btb_assoc
    import btb_pkg::*;
#(
    parameter int PC_W   = 16,
    parameter int SETS   = 64,
    parameter int STAT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              flush,
    input  logic              lk_valid,
    input  logic [PC_W-1:0]   lk_pc,
    output logic              pr_valid,
    output logic              pr_hit,
    output logic              pr_taken,
    output logic [PC_W-1:0]   pr_target,
    input  logic              up_valid,
    input  logic              up_is_br,
    input  logic [PC_W-1:0]   up_pc,
    input  logic              up_taken,
    input  logic [PC_W-1:0]   up_target,
    input  logic              up_pred_taken,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] br_cnt,
    output logic [STAT_W-1:0] hit_cnt,
    output logic [STAT_W-1:0] mispr_cnt
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = PC_W - IDX_W;

    logic [1:0][SETS-1:0] valid_q, valid_d;
    logic [SETS-1:0]      lru_q, lru_d;   // lru bit = way to evict next

    logic [TAG_W-1:0] tag_mem [2][SETS];
    logic [1:0]       ctr_mem [2][SETS];
    logic [PC_W-1:0]  tgt_mem [2][SETS];
    logic [1:0]       ctr_rd_q [2];
    logic [PC_W-1:0]  tgt_rd_q [2];

    logic pr_valid_q, pr_valid_d, pr_hit_q, pr_hit_d, pr_way_q, pr_way_d;

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic [1:0]       lk_match, up_match;
    logic             lk_way, lk_hit_use, up_way, up_hit, up_go, victim;
    logic             wr_en, wr_way;
    btb_entry_t       wr_entry;

    assign lk_idx = lk_pc[IDX_W-1:0];
    assign lk_tag = lk_pc[PC_W-1:IDX_W];
    assign up_idx = up_pc[IDX_W-1:0];
    assign up_tag = up_pc[PC_W-1:IDX_W];

    always_comb begin
        for (int w = 0; w < 2; w++) begin
            lk_match[w] = valid_q[w][lk_idx] && (tag_mem[w][lk_idx] == lk_tag);
            up_match[w] = valid_q[w][up_idx] && (tag_mem[w][up_idx] == up_tag);
        end
    end

    assign lk_way     = lk_match[1];
    assign lk_hit_use = lk_valid && en && (|lk_match);
    assign up_way     = up_match[1];
    assign up_hit     = |up_match;
    assign up_go      = up_valid && up_is_br && !flush;
    assign victim     = !valid_q[0][up_idx] ? 1'b0 :
                        !valid_q[1][up_idx] ? 1'b1 : lru_q[up_idx];
    // A not-taken miss leaves the table untouched; only hits and taken misses write.
    assign wr_en  = up_go && (up_hit || up_taken);
    assign wr_way = up_hit ? up_way : victim;

    always_comb begin
        wr_entry        = '0;
        wr_entry.valid  = 1'b1;
        wr_entry.tag    = BTB_MAX_W'(up_tag);
        wr_entry.ctr    = up_hit ? ctr_next(ctr_e'(ctr_mem[up_way][up_idx]), up_taken) : WT;
        wr_entry.target = BTB_MAX_W'(up_target);
    end

    // Update's LRU write is applied last so it overrides a same-set lookup hit.
    always_comb begin
        valid_d = valid_q;
        lru_d   = lru_q;
        if (lk_hit_use) lru_d[lk_idx] = ~lk_way;
        if (wr_en) begin
            valid_d[wr_way][up_idx] = 1'b1;
            lru_d[up_idx]           = ~wr_way;
        end
        if (flush) begin
            valid_d = '0;
            lru_d   = '0;
        end
    end

    always_comb begin
        pr_valid_d = lk_valid;
        pr_hit_d   = lk_hit_use && !flush;
        pr_way_d   = lk_way;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            lru_q      <= '0;
            pr_valid_q <= 1'b0;
            pr_hit_q   <= 1'b0;
            pr_way_q   <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            lru_q      <= lru_d;
            pr_valid_q <= pr_valid_d;
            pr_hit_q   <= pr_hit_d;
            pr_way_q   <= pr_way_d;
        end
    end

    // Payload arrays: synchronous read returns pre-write contents on a same-set collision.
    always_ff @(posedge clk) begin
        for (int w = 0; w < 2; w++) begin
            ctr_rd_q[w] <= ctr_mem[w][lk_idx];
            tgt_rd_q[w] <= tgt_mem[w][lk_idx];
        end
        if (wr_en) begin
            tag_mem[wr_way][up_idx] <= wr_entry.tag[TAG_W-1:0];
            ctr_mem[wr_way][up_idx] <= wr_entry.ctr;
            if (up_taken) tgt_mem[wr_way][up_idx] <= wr_entry.target[PC_W-1:0];
        end
    end

    assign pr_valid  = pr_valid_q;
    assign pr_hit    = pr_hit_q;
    assign pr_taken  = pr_hit_q && ctr_rd_q[pr_way_q][1];
    assign pr_target = pr_hit_q ? tgt_rd_q[pr_way_q] : '0;

    btb_stats #(.STAT_W(STAT_W)) u_stats (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (stat_clr),
        .br_inc    (up_valid && up_is_br),
        .hit_inc   (lk_hit_use),
        .mispr_inc (up_valid && up_is_br && (up_pred_taken != up_taken)),
        .br_cnt    (br_cnt),
        .hit_cnt   (hit_cnt),
        .mispr_cnt (mispr_cnt)
    );
endmodule

// File: tb/tb_btb_assoc.sv
// Bench for btb_assoc: behavioural BTB model feeds an expected-result queue
// that is drained against the prediction port; statistics compared to model counts.
module tb_btb_assoc;
    localparam int PC_W   = 16;
    localparam int SETS   = 64;
    localparam int STAT_W = 32;
    localparam int IDX_W  = 6;
    localparam int TAG_W  = PC_W - IDX_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en, flush, stat_clr;
    logic [STAT_W-1:0] br_cnt, hit_cnt, mispr_cnt;

    btb_assoc_if #(.PC_W(PC_W)) bus ();

    always #5 clk = ~clk;

    btb_assoc #(.PC_W(PC_W), .SETS(SETS), .STAT_W(STAT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .flush         (flush),
        .lk_valid      (bus.lk_valid),
        .lk_pc         (bus.lk_pc),
        .pr_valid      (bus.pr_valid),
        .pr_hit        (bus.pr_hit),
        .pr_taken      (bus.pr_taken),
        .pr_target     (bus.pr_target),
        .up_valid      (bus.up_valid),
        .up_is_br      (bus.up_is_br),
        .up_pc         (bus.up_pc),
        .up_taken      (bus.up_taken),
        .up_target     (bus.up_target),
        .up_pred_taken (bus.up_pred_taken),
        .stat_clr      (stat_clr),
        .br_cnt        (br_cnt),
        .hit_cnt       (hit_cnt),
        .mispr_cnt     (mispr_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [PC_W+1:0] exp_q[$];   // {hit, taken, target}

    bit              m_valid [2][SETS];
    logic [TAG_W-1:0] m_tag  [2][SETS];
    int              m_ctr   [2][SETS];
    logic [PC_W-1:0] m_tgt   [2][SETS];
    bit              m_lru   [SETS];
    int              m_br, m_hit, m_mispr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_valid[0][s] = 0;
            m_valid[1][s] = 0;
            m_lru[s]      = 0;
        end
        m_br = 0; m_hit = 0; m_mispr = 0;
        exp_q.delete();
    endtask

    task automatic idle_inputs();
        bus.lk_valid = 0; bus.lk_pc = '0;
        bus.up_valid = 0; bus.up_is_br = 0; bus.up_pc = '0;
        bus.up_taken = 0; bus.up_target = '0; bus.up_pred_taken = 0;
        flush = 0; stat_clr = 0;
    endtask

    // Apply current inputs to the model, then advance one clock.
    task automatic step();
        int li, ui, lw, uw, v;
        bit lraw, uhit, hit_e;
        li = int'(bus.lk_pc[IDX_W-1:0]);
        lraw = 0; lw = 0;
        for (int w = 0; w < 2; w++)
            if (m_valid[w][li] && m_tag[w][li] == bus.lk_pc[PC_W-1:IDX_W]) begin lraw = 1; lw = w; end
        if (bus.lk_valid) begin
            hit_e = lraw && en && !flush;
            exp_q.push_back({hit_e, hit_e && (m_ctr[lw][li] >= 2), hit_e ? m_tgt[lw][li] : 16'h0});
            if (lraw && en) begin m_hit++; m_lru[li] = (lw == 0); end
        end
        if (bus.up_valid && bus.up_is_br) begin
            m_br++;
            if (bus.up_pred_taken != bus.up_taken) m_mispr++;
            ui = int'(bus.up_pc[IDX_W-1:0]);
            uhit = 0; uw = 0;
            for (int w = 0; w < 2; w++)
                if (m_valid[w][ui] && m_tag[w][ui] == bus.up_pc[PC_W-1:IDX_W]) begin uhit = 1; uw = w; end
            if (!flush && uhit) begin
                m_ctr[uw][ui] = bus.up_taken ? ((m_ctr[uw][ui] == 3) ? 3 : m_ctr[uw][ui] + 1)
                                             : ((m_ctr[uw][ui] == 0) ? 0 : m_ctr[uw][ui] - 1);
                if (bus.up_taken) m_tgt[uw][ui] = bus.up_target;
                m_lru[ui] = (uw == 0);
            end else if (!flush && bus.up_taken) begin
                v = !m_valid[0][ui] ? 0 : !m_valid[1][ui] ? 1 : int'(m_lru[ui]);
                m_valid[v][ui] = 1;
                m_tag[v][ui]   = bus.up_pc[PC_W-1:IDX_W];
                m_ctr[v][ui]   = 2;
                m_tgt[v][ui]   = bus.up_target;
                m_lru[ui]      = (v == 0);
            end
        end
        if (flush)
            for (int s = 0; s < SETS; s++) begin m_valid[0][s] = 0; m_valid[1][s] = 0; m_lru[s] = 0; end
        if (stat_clr) begin m_br = 0; m_hit = 0; m_mispr = 0; end
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [PC_W-1:0] pc);
        bus.lk_valid = 1; bus.lk_pc = pc;
        step();
        bus.lk_valid = 0;
    endtask

    task automatic update(input logic [PC_W-1:0] pc, input logic tk, input logic [PC_W-1:0] tgt,
                          input logic pred);
        bus.up_valid = 1; bus.up_is_br = 1; bus.up_pc = pc;
        bus.up_taken = tk; bus.up_target = tgt; bus.up_pred_taken = pred;
        step();
        bus.up_valid = 0; bus.up_is_br = 0;
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_br_cnt"}, br_cnt, m_br);
        check({tag, "_hit_cnt"}, hit_cnt, m_hit);
        check({tag, "_mispr_cnt"}, mispr_cnt, m_mispr);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pr_valid"}, bus.pr_valid, 0);
        check({tag, "_pr_hit"}, bus.pr_hit, 0);
        check({tag, "_pr_taken"}, bus.pr_taken, 0);
        check({tag, "_pr_target"}, bus.pr_target, 0);
        check({tag, "_stats"}, {br_cnt, hit_cnt, mispr_cnt}, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.pr_valid) begin
            if (exp_q.size() == 0) check("pr_valid_unexpected", 1, 0);
            else check("pr_result", {bus.pr_hit, bus.pr_taken, bus.pr_target}, exp_q.pop_front());
        end
    end

    initial begin
        logic [PC_W-1:0] pool [8];
        pool = '{16'h0004, 16'h0044, 16'h0084, 16'h00C4, 16'h0104, 16'h0010, 16'h0050, 16'h0144};
        idle_inputs();
        en = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1;
        step();

        lookup(16'h0104);
        check_stats("cold");

        update(16'h0104, 1, 16'h0200, 0);
        lookup(16'h0104);
        check("alloc_hit_cnt", hit_cnt, 1);
        check_stats("alloc");

        update(16'h0104, 0, 16'h0000, 1);
        update(16'h0104, 0, 16'h0000, 0);
        update(16'h0104, 0, 16'h0000, 0);
        lookup(16'h0104);
        check("nt_mispr_cnt", mispr_cnt, 2);
        check_stats("nt");

        update(16'h0004, 1, 16'h1000, 1);
        update(16'h0044, 1, 16'h1100, 1);
        lookup(16'h0004);
        update(16'h0084, 1, 16'h1200, 1);
        lookup(16'h0044);
        lookup(16'h0004);
        lookup(16'h0084);
        check_stats("lru");

        bus.up_valid = 1; bus.up_is_br = 1; bus.up_pc = 16'h0010; bus.up_taken = 1;
        bus.up_target = 16'h0ABC; bus.up_pred_taken = 0;
        bus.lk_valid = 1; bus.lk_pc = 16'h0010;
        step();
        idle_inputs();
        lookup(16'h0010);

        bus.up_valid = 1; bus.up_is_br = 0; bus.up_pc = 16'h0020; bus.up_taken = 1; bus.up_target = 16'h0333;
        step();
        idle_inputs();
        lookup(16'h0020);
        check_stats("notbr");

        for (int i = 0; i < 4; i++) update(16'h0104, 1, 16'h0400, 1);
        update(16'h0104, 0, 16'h0000, 0);
        lookup(16'h0104);

        bus.up_valid = 1; bus.up_is_br = 1; bus.up_pc = 16'h0030; bus.up_taken = 1; bus.up_target = 16'h0777;
        bus.lk_valid = 1; bus.lk_pc = 16'h0104;
        flush = 1;
        step();
        idle_inputs();
        lookup(16'h0104);
        lookup(16'h0004);
        lookup(16'h0084);
        lookup(16'h0030);
        lookup(16'h0010);

        update(16'h0104, 1, 16'h0500, 1);
        en = 0;
        lookup(16'h0104);
        check("en_off_hit_cnt", hit_cnt, m_hit);
        en = 1;
        lookup(16'h0104);

        stat_clr = 1;
        bus.up_valid = 1; bus.up_is_br = 1; bus.up_pc = 16'h0104; bus.up_taken = 0; bus.up_pred_taken = 1;
        step();
        idle_inputs();
        check("stat_clr", {br_cnt, hit_cnt, mispr_cnt}, 0);

        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 39) == 0);
            stat_clr = ($urandom_range(0, 49) == 0);
            bus.lk_valid = $urandom_range(0, 1);
            bus.lk_pc = pool[$urandom_range(0, 7)];
            bus.up_valid = $urandom_range(0, 1);
            bus.up_is_br = ($urandom_range(0, 4) != 0);
            bus.up_pc = pool[$urandom_range(0, 7)];
            bus.up_taken = $urandom_range(0, 1);
            bus.up_target = PC_W'($urandom_range(0, 16'hFFFF));
            bus.up_pred_taken = $urandom_range(0, 1);
            step();
        end
        idle_inputs();
        en = 1;
        step();
        check_stats("random");

        update(16'h0104, 1, 16'h0600, 1);
        bus.lk_valid = 1; bus.lk_pc = 16'h0104;
        bus.up_valid = 1; bus.up_is_br = 1; bus.up_pc = 16'h0050; bus.up_taken = 1;
        #3;
        rst_n = 0;
        idle_inputs();
        model_reset();
        @(posedge clk);
        #1;
        check_reset_outputs("midreset");
        rst_n = 1;
        lookup(16'h0104);
        lookup(16'h0050);
        step();
        check_stats("post_reset");

        step();
        check("exp_q_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
